// File: rtl/cm0_mtx_pkg.sv
// Shared definitions for the cm0 bus matrix default slave.
// Holds the HRESP and HTRANS encodings and the default-slave FSM state type.
// No logic; imported by the default slave and its error logger.
package cm0_mtx_pkg;

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    TRN_IDLE   = 2'b00,
    TRN_BUSY   = 2'b01,
    TRN_NONSEQ = 2'b10,
    TRN_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_ERR1 = 3'd2,
    ST_ERR2 = 3'd3,
    ST_OKD  = 3'd4
  } dslv_state_t;

endpackage

// File: rtl/cm0_mtx_default_slave_ext_if.sv
// AHB-Lite slave-side bundle for the cm0 matrix default slave.
// master: drives address phase (HSEL/HTRANS/HREADY/HADDR/HWRITE), sees the response.
// slave:  sees the address phase, drives HREADYOUT/HRESP/HRDATA.
interface cm0_mtx_default_slave_ext_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [1:0]            HTRANS;
  logic                  HREADY;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [31:0]           HRDATA;

  modport master (
    output HSEL, HTRANS, HREADY, HADDR, HWRITE,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HTRANS, HREADY, HADDR, HWRITE,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/cm0_mtx_err_log.sv
// Miss logger: first-fault address/direction, saturating miss count, sticky IRQ.
// Latency: updates one cycle after the accept/clear cycle; no backpressure.
// Ports: clk_i/rst_ni, accept_i + haddr_i/hwrite_i (miss), err_clr_i; err_* outputs.
module cm0_mtx_err_log #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  accept_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic                  err_clr_i,
  output logic                  err_irq_o,
  output logic [ADDR_WIDTH-1:0] err_addr_o,
  output logic                  err_write_o,
  output logic [CNT_WIDTH-1:0]  err_count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                  irq_q,   irq_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic                  write_q, write_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  always_comb begin
    irq_d   = irq_q;
    addr_d  = addr_q;
    write_d = write_q;
    count_d = count_q;
    if (accept_i) begin
      // A clear in the same cycle as a miss loses: the miss becomes the first fault.
      if (!irq_q || err_clr_i) begin
        addr_d  = haddr_i;
        write_d = hwrite_i;
      end
      irq_d = 1'b1;
      if (err_clr_i)
        count_d = CNT_ONE;
      else if (count_q != CNT_MAX)
        count_d = count_q + CNT_ONE;
    end else if (err_clr_i) begin
      // Capture registers deliberately hold their last value across a clear.
      irq_d   = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q   <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      count_q <= '0;
    end else begin
      irq_q   <= irq_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      count_q <= count_d;
    end
  end

  assign err_irq_o   = irq_q;
  assign err_addr_o  = addr_q;
  assign err_write_o = write_q;
  assign err_count_o = count_q;

endmodule

// File: rtl/cm0_mtx_default_slave_ext.sv
// Default slave for cm0 matrix output stages: terminates unmapped AHB-Lite transfers
// with WAIT_STATES stall cycles then a two-cycle ERROR or single-cycle OKAY (RAZ/WI).
// Latency: ERR1 at N+1+W, ERR2 at N+2+W (or OKD at N+1+W); stalls via HREADYOUT only.
// Ports: HCLK/HRESETn, ahb (slave modport), ERR_CLR in, ERR_IRQ/ADDR/WRITE/COUNT out.
module cm0_mtx_default_slave_ext
  import cm0_mtx_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0,
  parameter int ERR_MODE    = 1,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  cm0_mtx_default_slave_ext_if.slave     ahb,
  input  logic                           ERR_CLR,
  output logic                           ERR_IRQ,
  output logic [ADDR_WIDTH-1:0]          ERR_ADDR,
  output logic                           ERR_WRITE,
  output logic [CNT_WIDTH-1:0]           ERR_COUNT
);

  // Wait counter is loaded with W-1 so the WAIT state lasts exactly W cycles.
  localparam logic [3:0]      WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  // State and registered outputs entered once the stall (if any) is over.
  localparam dslv_state_t     RESP_ST   = (ERR_MODE != 0) ? ST_ERR1 : ST_OKD;
  localparam logic            RESP_RDY  = (ERR_MODE != 0) ? 1'b0 : 1'b1;
  localparam logic [1:0]      RESP_CODE = (ERR_MODE != 0) ? RSP_ERROR : RSP_OKAY;

  dslv_state_t state_q;
  logic [3:0]  wait_q;
  logic        hreadyout_q;
  logic [1:0]  hresp_q;
  logic        accept;

  // Only NONSEQ/SEQ (HTRANS[1]) with the bus ready start a transfer.
  assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      wait_q      <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RSP_OKAY;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (wait_q == 4'd0) begin
            state_q     <= RESP_ST;
            hreadyout_q <= RESP_RDY;
            hresp_q     <= RESP_CODE;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= RSP_ERROR;
        end
        default: begin
          // IDLE, ERR2 and OKD all see HREADY high, so a new miss may start here.
          if (accept && (WAIT_STATES > 0)) begin
            state_q     <= ST_WAIT;
            wait_q      <= WAIT_LOAD;
            hreadyout_q <= 1'b0;
            hresp_q     <= RSP_OKAY;
          end else if (accept) begin
            state_q     <= RESP_ST;
            hreadyout_q <= RESP_RDY;
            hresp_q     <= RESP_CODE;
          end else begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RSP_OKAY;
          end
        end
      endcase
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = 32'd0;

  cm0_mtx_err_log #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_err_log (
    .clk_i       (HCLK),
    .rst_ni      (HRESETn),
    .accept_i    (accept),
    .haddr_i     (ahb.HADDR),
    .hwrite_i    (ahb.HWRITE),
    .err_clr_i   (ERR_CLR),
    .err_irq_o   (ERR_IRQ),
    .err_addr_o  (ERR_ADDR),
    .err_write_o (ERR_WRITE),
    .err_count_o (ERR_COUNT)
  );

endmodule

// File: tb/tb_cm0_mtx_default_slave_ext.sv
// Randomised bench for the matrix default slave, four parameter sets in parallel.
// Each set: a driver that issues legal AHB traffic and predicts outputs from a
// transaction-level model, and a monitor that pops predictions and compares.
module tb_cm0_mtx_default_slave_ext;

  localparam int NCFG = 4;
  localparam int RUN  = 1500;

  typedef struct {
    bit       rdy;
    bit [1:0] resp;
  } cyc_t;

  typedef struct {
    bit        rdy;
    bit [1:0]  resp;
    bit        irq;
    bit [31:0] addr;
    bit        wr;
    int        cnt;
  } exp_t;

  logic clk = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cfg, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h at %0t", cfg, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W = (g == 1) ? 3 : (g == 3) ? 2 : 0;
    localparam int E = (g == 2) ? 0 : 1;
    localparam int C = (g == 3) ? 2 : 8;

    logic         rst_n;
    logic         err_clr;
    logic         err_irq;
    logic [31:0]  err_addr;
    logic         err_write;
    logic [C-1:0] err_count;

    cm0_mtx_default_slave_ext_if #(.ADDR_WIDTH(32)) bus ();

    cm0_mtx_default_slave_ext #(
      .ADDR_WIDTH  (32),
      .WAIT_STATES (W),
      .ERR_MODE    (E),
      .CNT_WIDTH   (C)
    ) dut (
      .HCLK      (clk),
      .HRESETn   (rst_n),
      .ahb       (bus.slave),
      .ERR_CLR   (err_clr),
      .ERR_IRQ   (err_irq),
      .ERR_ADDR  (err_addr),
      .ERR_WRITE (err_write),
      .ERR_COUNT (err_count)
    );

    exp_t sb_q[$];
    bit   mon_en = 1'b0;
    bit   done   = 1'b0;

    // Monitor: one prediction per cycle, checked mid-cycle.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (mon_en && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("hreadyout", g, 64'(bus.HREADYOUT), 64'(e.rdy));
          chk("hresp",     g, 64'(bus.HRESP),     64'(e.resp));
          chk("hrdata",    g, 64'(bus.HRDATA),    64'd0);
          chk("err_irq",   g, 64'(err_irq),       64'(e.irq));
          chk("err_addr",  g, 64'(err_addr),      64'(e.addr));
          chk("err_write", g, 64'(err_write),     64'(e.wr));
          chk("err_count", g, 64'(err_count),     64'(e.cnt));
        end
      end
    end

    // Driver + reference model.
    initial begin
      cyc_t      cur, nxt;
      cyc_t      pend[$];
      bit        cur_busy, tail, hit, hs, hr, hw, clr, acc;
      bit [1:0]  ht;
      bit [31:0] ha;
      int        miss, maxc;
      bit        have, m_wr;
      bit [31:0] m_addr;

      maxc = (1 << C) - 1;
      miss = 0; have = 1'b0; m_addr = 32'd0; m_wr = 1'b0; hit = 1'b0;
      rst_n = 1'b0; err_clr = 1'b0;
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HREADY = 1'b1;
      bus.HADDR = 32'd0; bus.HWRITE = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cur = '{1'b1, 2'b00};
      cur_busy = 1'b0;
      sb_q.push_back('{1'b1, 2'b00, 1'b0, 32'd0, 1'b0, 0});
      mon_en = 1'b1;

      for (int k = 0; k < RUN + 200; k++) begin
        tail = (k >= RUN);
        // Tail phase forces misses until the DUT sits in its first response
        // cycle (ERR1, or OKD when terminating with OKAY), then resets it there.
        if (tail && cur_busy && cur.rdy == (E == 0) && cur.resp == ((E != 0) ? 2'b01 : 2'b00)) begin
          hit = 1'b1;
          break;
        end
        hs = tail || ($urandom_range(0, 3) != 0);
        ht = tail ? 2'b10 : 2'($urandom_range(0, 3));
        hw = 1'($urandom_range(0, 1));
        ha = $urandom;
        if (!cur.rdy)      hr = 1'b0;
        else if (cur_busy) hr = 1'b1;
        else               hr = tail || ($urandom_range(0, 5) != 0);
        clr = (g == 3) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 15) == 0);
        bus.HSEL = hs; bus.HTRANS = ht; bus.HREADY = hr;
        bus.HADDR = ha; bus.HWRITE = hw; err_clr = clr;

        acc = hs && hr && ht[1];
        if (acc) begin
          for (int i = 0; i < W; i++) pend.push_back('{1'b0, 2'b00});
          if (E != 0) begin
            pend.push_back('{1'b0, 2'b01});
            pend.push_back('{1'b1, 2'b01});
          end else begin
            pend.push_back('{1'b1, 2'b00});
          end
        end
        if (clr) begin
          miss = 0;
          have = 1'b0;
        end
        if (acc) begin
          if (!have) begin
            m_addr = ha;
            m_wr   = hw;
          end
          have = 1'b1;
          miss++;
        end
        if (pend.size() > 0) begin
          nxt = pend.pop_front();
          cur_busy = 1'b1;
        end else begin
          nxt = '{1'b1, 2'b00};
          cur_busy = 1'b0;
        end
        cur = nxt;
        sb_q.push_back('{nxt.rdy, nxt.resp, have, m_addr, m_wr, (miss > maxc) ? maxc : miss});
        @(posedge clk);
        #1;
      end

      if (!hit) begin
        chk("reach_rst_point", g, 64'd0, 64'd1);
      end else begin
        mon_en = 1'b0;
        chk("pre_rst_hreadyout", g, 64'(bus.HREADYOUT), 64'(cur.rdy));
        chk("pre_rst_hresp",     g, 64'(bus.HRESP),     64'(cur.resp));
        chk("pre_rst_irq",       g, 64'(err_irq),       64'(have));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_hreadyout", g, 64'(bus.HREADYOUT), 64'd1);
        chk("rst_hresp",     g, 64'(bus.HRESP),     64'd0);
        chk("rst_err_irq",   g, 64'(err_irq),       64'd0);
        chk("rst_err_addr",  g, 64'(err_addr),      64'd0);
        chk("rst_err_write", g, 64'(err_write),     64'd0);
        chk("rst_err_count", g, 64'(err_count),     64'd0);
      end
      done = 1'b1;
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      @(posedge clk);
      all_done = cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done;
    end
    chk("all_configs_done", -1, 64'(all_done), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
